wave_generator: RTL and testbench



---
 rtl/wave_generator.sv | 197 +++++++++++++++++++
 tb/tb_wave_generator.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_generator.sv
// -----------------------------------------------------------------------------
// wave_generator
//   Enable-gated periodic waveform source: sawtooth-up, sawtooth-down,
//   triangle and (optionally) square, between programmable bounds lo/hi with a
//   programmable step. Out of reset it runs the plain 0..2^N-1 triangle.
//
//   Optional feature macro: WAVE_GENERATOR_SQUARE_EN
//     defined     -> SQUARE mode plus its STEP_W-bit half-period counter
//     not defined -> no counter; mode 3 at load is taken as TRIANGLE
//
// Ports
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   ena   in   advance one step when high, hold otherwise
//   load  in   latch mode/lo/hi/step and restart the waveform
//   mode  in   [1:0] 0 SAW_UP, 1 SAW_DOWN, 2 TRIANGLE, 3 SQUARE
//   lo    in   [N-1:0] lower bound (unsigned)
//   hi    in   [N-1:0] upper bound (unsigned)
//   step  in   [STEP_W-1:0] increment per enabled cycle (SQUARE: half-period)
//   out   out  [N-1:0] waveform sample (registered)
//   dir   out  0 rising/low phase, 1 falling/high phase (registered)
//   wrap  out  one-cycle pulse on the first sample of a new period (registered)
// -----------------------------------------------------------------------------
module wave_generator #(
   parameter int N      = 8,
   parameter int STEP_W = N
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              load,
   input  logic [1:0]        mode,
   input  logic [N-1:0]      lo,
   input  logic [N-1:0]      hi,
   input  logic [STEP_W-1:0] step,
   output logic [N-1:0]      out,
   output logic              dir,
   output logic              wrap
);

   typedef enum logic [1:0] {
      SAW_UP   = 2'd0,
      SAW_DOWN = 2'd1,
      TRIANGLE = 2'd2,
      SQUARE   = 2'd3
   } mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   // One bit wider than the widest operand so bound + step never wraps.
   localparam int AW = ((STEP_W > N) ? STEP_W : N) + 1;

   mode_t             mode_q, load_mode;
   logic [N-1:0]      lo_q, hi_q, hi_eff;
   logic [STEP_W-1:0] step_q;
   logic [N-1:0]      out_q, out_d;
   dir_t              dir_q, dir_d;
   logic              wrap_q, wrap_d;
   logic              degenerate;

   logic [AW-1:0]     out_x, lo_x, hi_x, step_x, up_sum, lo_sum;

`ifdef WAVE_GENERATOR_SQUARE_EN
   logic [STEP_W-1:0] cnt_q, cnt_d;
`endif

   assign out_x  = AW'(out_q);
   assign lo_x   = AW'(lo_q);
   assign hi_x   = AW'(hi_q);
   assign step_x = AW'(step_q);
   assign up_sum = out_x + step_x;
   assign lo_sum = lo_x + step_x;

   // lo >= hi collapses the range to the single value lo.
   assign hi_eff     = (lo >= hi) ? lo : hi;
   assign degenerate = (lo_q == hi_q);

   always_comb begin
      load_mode = mode_t'(mode);
`ifndef WAVE_GENERATOR_SQUARE_EN
      if (load_mode == SQUARE) load_mode = TRIANGLE;
`endif
   end

   // Next sample for an enabled, non-load cycle.
   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      out_d  = out_q;
      dir_d  = dir_q;
      wrap_d = 1'b0;
`ifdef WAVE_GENERATOR_SQUARE_EN
      cnt_d  = cnt_q;
`endif
      if (ena && !degenerate) begin
         case (mode_q)
            SAW_UP: begin
               if (up_sum > hi_x) begin
                  out_d  = lo_q;
                  wrap_d = 1'b1;
               end else begin
                  out_d = N'(up_sum);
               end
            end
            SAW_DOWN: begin
               // out >= lo + step here, so the subtraction cannot underflow.
               if (out_x < lo_sum) begin
                  out_d  = hi_q;
                  wrap_d = 1'b1;
               end else begin
                  out_d = N'(out_x - step_x);
               end
            end
`ifdef WAVE_GENERATOR_SQUARE_EN
            SQUARE: begin
               if (cnt_q == (step_q - STEP_W'(1))) begin
                  cnt_d = '0;
                  if (out_q == hi_q) begin
                     out_d  = lo_q;
                     dir_d  = DIR_UP;
                     wrap_d = 1'b1;
                  end else begin
                     out_d = hi_q;
                     dir_d = DIR_DOWN;
                  end
               end else begin
                  cnt_d = cnt_q + STEP_W'(1);
               end
            end
`endif
            default: begin
               // Triangle: the last step clamps onto the bound, so each
               // extreme is shown for exactly one enabled cycle per period.
               if (dir_q == DIR_UP) begin
                  if (up_sum >= hi_x) begin
                     out_d = hi_q;
                     dir_d = DIR_DOWN;
                  end else begin
                     out_d = N'(up_sum);
                  end
               end else begin
                  if (out_x <= lo_sum) begin
                     out_d  = lo_q;
                     dir_d  = DIR_UP;
                     wrap_d = 1'b1;
                  end else begin
                     out_d = N'(out_x - step_x);
                  end
               end
            end
         endcase
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= TRIANGLE;
         lo_q   <= '0;
         hi_q   <= '1;
         step_q <= STEP_W'(1);
         out_q  <= '0;
         dir_q  <= DIR_UP;
         wrap_q <= 1'b0;
`ifdef WAVE_GENERATOR_SQUARE_EN
         cnt_q  <= '0;
`endif
      end else if (load) begin
         mode_q <= load_mode;
         lo_q   <= lo;
         hi_q   <= hi_eff;
         step_q <= (step == '0) ? STEP_W'(1) : step;
         out_q  <= (load_mode == SAW_DOWN) ? hi_eff : lo;
         dir_q  <= (load_mode == SAW_DOWN) ? DIR_DOWN : DIR_UP;
         wrap_q <= 1'b0;
`ifdef WAVE_GENERATOR_SQUARE_EN
         cnt_q  <= '0;
`endif
      end else begin
         out_q  <= out_d;
         dir_q  <= dir_d;
         wrap_q <= wrap_d;
`ifdef WAVE_GENERATOR_SQUARE_EN
         cnt_q  <= cnt_d;
`endif
      end
   end

   assign out  = out_q;
   assign dir  = dir_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_wave_generator.sv
// -----------------------------------------------------------------------------
// tb_wave_generator
//   Self-checking bench for wave_generator (N = STEP_W = 8). Directed
//   scenarios compare against literal expected sequences; the randomized
//   scenario compares against a reference model that builds one full period
//   of the waveform as a list of samples and walks it with a phase index.
// -----------------------------------------------------------------------------
module tb_wave_generator;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst, ena, load;
   logic [1:0]   mode;
   logic [N-1:0] lo, hi, step;
   logic [N-1:0] out;
   logic         dir, wrap;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: one period of samples and the phase within it.
   int       seq_out[$];
   int       seq_dir[$];
   int       p;
   bit       deg;
   int       exp_out;
   bit       exp_dir, exp_wrap;

   wave_generator #(.N(N), .STEP_W(N)) dut (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .load (load),
      .mode (mode),
      .lo   (lo),
      .hi   (hi),
      .step (step),
      .out  (out),
      .dir  (dir),
      .wrap (wrap)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic model_load(input int m, input int l, input int h, input int s);
      int v;
      seq_out.delete();
      seq_dir.delete();
      if (s == 0) s = 1;
`ifndef WAVE_GENERATOR_SQUARE_EN
      if (m == 3) m = 2;
`endif
      deg = (l >= h);
      if (deg) begin
         seq_out.push_back(l);
         seq_dir.push_back((m == 1) ? 1 : 0);
      end else begin
         case (m)
            0: begin
               v = l;
               seq_out.push_back(v); seq_dir.push_back(0);
               while (v + s <= h) begin
                  v += s;
                  seq_out.push_back(v); seq_dir.push_back(0);
               end
            end
            1: begin
               v = h;
               seq_out.push_back(v); seq_dir.push_back(1);
               while (v >= l + s) begin
                  v -= s;
                  seq_out.push_back(v); seq_dir.push_back(1);
               end
            end
            3: begin
               repeat (s) begin seq_out.push_back(l); seq_dir.push_back(0); end
               repeat (s) begin seq_out.push_back(h); seq_dir.push_back(1); end
            end
            default: begin
               v = l;
               seq_out.push_back(v); seq_dir.push_back(0);
               forever begin
                  if (v + s >= h) begin
                     v = h;
                     seq_out.push_back(v); seq_dir.push_back(1);
                     break;
                  end
                  v += s;
                  seq_out.push_back(v); seq_dir.push_back(0);
               end
               while (v > l + s) begin
                  v -= s;
                  seq_out.push_back(v); seq_dir.push_back(1);
               end
            end
         endcase
      end
      p        = 0;
      exp_out  = seq_out[0];
      exp_dir  = seq_dir[0][0];
      exp_wrap = 1'b0;
   endtask

   task automatic model_step();
      if (deg) begin
         exp_wrap = 1'b0;
      end else begin
         p        = (p + 1) % seq_out.size();
         exp_out  = seq_out[p];
         exp_dir  = seq_dir[p][0];
         exp_wrap = (p == 0);
      end
   endtask

   // Drive one cycle of inputs, wait past the edge, advance the model.
   task automatic cycle(input bit r, input bit l, input bit e,
                        input int m, input int lv, input int hv, input int sv);
      rst  = r;
      load = l;
      ena  = e;
      mode = 2'(m);
      lo   = 8'(lv);
      hi   = 8'(hv);
      step = 8'(sv);
      @(posedge clk);
      #1;
      if (r)      model_load(2, 0, 255, 1);
      else if (l) model_load(m, lv, hv, sv);
      else if (e) model_step();
      else        exp_wrap = 1'b0;
   endtask

   task automatic test_reset();
      cycle(1, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (out !== 8'd0 || dir !== 1'b0 || wrap !== 1'b0) begin
         n_bad++;
         $display("FAIL reset: got out=%0d dir=%0b wrap=%0b, want 0/0/0", out, dir, wrap);
      end
   endtask

   task automatic test_default_triangle();
      int eo;
      bit ed, ew;
      for (int k = 1; k <= 511; k++) begin
         // Config inputs carry garbage; they must be ignored without load.
         cycle(0, 0, 1, $urandom_range(0, 3), $urandom_range(0, 255),
               $urandom_range(0, 255), $urandom_range(0, 255));
         eo = (k <= 255) ? k : ((k <= 510) ? 510 - k : k - 510);
         ed = (k >= 255 && k <= 509);
         ew = (k == 510);
         n_cmp++;
         if (out !== 8'(eo) || dir !== ed || wrap !== ew) begin
            n_bad++;
            $display("FAIL default_tri[%0d]: got out=%0d dir=%0b wrap=%0b, want %0d/%0b/%0b",
                     k, out, dir, wrap, eo, ed, ew);
         end
      end
   endtask

   task automatic test_saw_up();
      int e_out[5] = '{10, 14, 18, 10, 14};
      int e_wr[5]  = '{0, 0, 0, 1, 0};
      cycle(0, 1, 1, 0, 10, 20, 4);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) cycle(0, 0, 1, 0, 0, 0, 0);
         n_cmp++;
         if (out !== 8'(e_out[i]) || dir !== 1'b0 || wrap !== 1'(e_wr[i])) begin
            n_bad++;
            $display("FAIL saw_up[%0d]: got out=%0d dir=%0b wrap=%0b, want %0d/0/%0d",
                     i, out, dir, wrap, e_out[i], e_wr[i]);
         end
      end
   endtask

   task automatic test_saw_down();
      int e_out[5] = '{20, 17, 14, 11, 20};
      int e_wr[5]  = '{0, 0, 0, 0, 1};
      cycle(0, 1, 0, 1, 10, 20, 3);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) cycle(0, 0, 1, 0, 0, 0, 0);
         n_cmp++;
         if (out !== 8'(e_out[i]) || dir !== 1'b1 || wrap !== 1'(e_wr[i])) begin
            n_bad++;
            $display("FAIL saw_down[%0d]: got out=%0d dir=%0b wrap=%0b, want %0d/1/%0d",
                     i, out, dir, wrap, e_out[i], e_wr[i]);
         end
      end
   endtask

   task automatic test_triangle_small();
      int e_out[6] = '{5, 8, 9, 6, 5, 8};
      int e_dir[6] = '{0, 0, 1, 1, 0, 0};
      int e_wr[6]  = '{0, 0, 0, 0, 1, 0};
      cycle(0, 1, 1, 2, 5, 9, 3);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) cycle(0, 0, 1, 0, 0, 0, 0);
         n_cmp++;
         if (out !== 8'(e_out[i]) || dir !== 1'(e_dir[i]) || wrap !== 1'(e_wr[i])) begin
            n_bad++;
            $display("FAIL tri_small[%0d]: got out=%0d dir=%0b wrap=%0b, want %0d/%0d/%0d",
                     i, out, dir, wrap, e_out[i], e_dir[i], e_wr[i]);
         end
      end
   endtask

   task automatic test_ena_gaps();
      int e_ena[5] = '{1, 0, 0, 1, 1};
      int e_out[5] = '{8, 8, 8, 9, 6};
      int e_dir[5] = '{0, 0, 0, 1, 1};
      cycle(0, 1, 1, 2, 5, 9, 3);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 1'(e_ena[i]), 0, 0, 0, 0);
         n_cmp++;
         if (out !== 8'(e_out[i]) || dir !== 1'(e_dir[i]) || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL ena_gap[%0d]: got out=%0d dir=%0b wrap=%0b, want %0d/%0d/0",
                     i, out, dir, wrap, e_out[i], e_dir[i]);
         end
      end
   endtask

   task automatic test_load_rst();
      cycle(0, 1, 0, 0, 10, 20, 4);
      cycle(0, 0, 1, 0, 0, 0, 0);
      cycle(1, 1, 1, 1, 10, 20, 3);
      n_cmp++;
      if (out !== 8'd0 || dir !== 1'b0 || wrap !== 1'b0) begin
         n_bad++;
         $display("FAIL load_rst: got out=%0d dir=%0b wrap=%0b, want 0/0/0", out, dir, wrap);
      end
      for (int i = 1; i <= 2; i++) begin
         cycle(0, 0, 1, 0, 0, 0, 0);
         n_cmp++;
         if (out !== 8'(i) || dir !== 1'b0 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL load_rst_resume[%0d]: got out=%0d dir=%0b wrap=%0b, want %0d/0/0",
                     i, out, dir, wrap, i);
         end
      end
   endtask

   task automatic test_degenerate();
      cycle(0, 1, 1, 0, 30, 30, 0);
      for (int i = 0; i < 12; i++) begin
         cycle(0, 0, 1, 0, 0, 0, 0);
         n_cmp++;
         if (out !== 8'd30 || dir !== 1'b0 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL degen_eq[%0d]: got out=%0d dir=%0b wrap=%0b, want 30/0/0",
                     i, out, dir, wrap);
         end
      end
      cycle(0, 1, 0, 1, 50, 40, 2);
      for (int i = 0; i < 8; i++) begin
         cycle(0, 0, 1, 0, 0, 0, 0);
         n_cmp++;
         if (out !== 8'd50 || dir !== 1'b1 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL degen_inv[%0d]: got out=%0d dir=%0b wrap=%0b, want 50/1/0",
                     i, out, dir, wrap);
         end
      end
   endtask

   task automatic test_square();
`ifdef WAVE_GENERATOR_SQUARE_EN
      int e_out[7] = '{2, 2, 2, 200, 200, 200, 2};
      int e_dir[7] = '{0, 0, 0, 1, 1, 1, 0};
      int e_wr[7]  = '{0, 0, 0, 0, 0, 0, 1};
`else
      int e_out[7] = '{2, 5, 8, 11, 14, 17, 20};
      int e_dir[7] = '{0, 0, 0, 0, 0, 0, 0};
      int e_wr[7]  = '{0, 0, 0, 0, 0, 0, 0};
`endif
      cycle(0, 1, 1, 3, 2, 200, 3);
      for (int i = 0; i < 7; i++) begin
         if (i > 0) cycle(0, 0, 1, 0, 0, 0, 0);
         n_cmp++;
         if (out !== 8'(e_out[i]) || dir !== 1'(e_dir[i]) || wrap !== 1'(e_wr[i])) begin
            n_bad++;
            $display("FAIL square[%0d]: got out=%0d dir=%0b wrap=%0b, want %0d/%0d/%0d",
                     i, out, dir, wrap, e_out[i], e_dir[i], e_wr[i]);
         end
      end
   endtask

   task automatic test_rst_mid();
      cycle(0, 1, 0, 1, 10, 20, 3);
      cycle(0, 0, 1, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0, 0);
      cycle(1, 0, 1, 0, 0, 0, 0);
      n_cmp++;
      if (out !== 8'd0 || dir !== 1'b0 || wrap !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid: got out=%0d dir=%0b wrap=%0b, want 0/0/0", out, dir, wrap);
      end
      for (int i = 1; i <= 3; i++) begin
         cycle(0, 0, 1, 0, 0, 0, 0);
         n_cmp++;
         if (out !== 8'(i) || dir !== 1'b0 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_resume[%0d]: got out=%0d dir=%0b wrap=%0b, want %0d/0/0",
                     i, out, dir, wrap, i);
         end
      end
   endtask

   task automatic random_cfg(output int m, output int lv, output int hv, output int sv);
      m  = $urandom_range(0, 3);
      lv = $urandom_range(0, 200);
      if ($urandom_range(0, 7) == 0) hv = $urandom_range(0, lv);
      else                           hv = lv + $urandom_range(1, 55);
      if ($urandom_range(0, 4) == 0) sv = $urandom_range(0, 255);
      else                           sv = $urandom_range(0, 12);
   endtask

   task automatic test_random();
      int m, lv, hv, sv;
      bit r, l, e;
      for (int round = 0; round < 30; round++) begin
         random_cfg(m, lv, hv, sv);
         cycle(0, 1, 1'($urandom_range(0, 1)), m, lv, hv, sv);
         for (int c = 0; c < 80; c++) begin
            random_cfg(m, lv, hv, sv);
            r = ($urandom_range(0, 199) == 0);
            l = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 3) != 0);
            cycle(r, l, e, m, lv, hv, sv);
            n_cmp++;
            if (out !== 8'(exp_out) || dir !== exp_dir || wrap !== exp_wrap) begin
               n_bad++;
               $display("FAIL random[%0d.%0d]: got out=%0d dir=%0b wrap=%0b, want %0d/%0b/%0b",
                        round, c, out, dir, wrap, exp_out, exp_dir, exp_wrap);
            end
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      load = 1'b0;
      ena  = 1'b0;
      mode = 2'd0;
      lo   = '0;
      hi   = '0;
      step = '0;
      test_reset();
      test_default_triangle();
      test_saw_up();
      test_saw_down();
      test_triangle_small();
      test_ena_gaps();
      test_load_rst();
      test_degenerate();
      test_square();
      test_rst_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
